// File: rtl/exception_commit_pkg.sv
// Shared constants for the exception commit unit: Cause.ExcCode values,
// commit_exc flag bit positions and FSM state encodings.
package exception_commit_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int EXC_B_ADEL_F = 0;
  localparam int EXC_B_RI     = 1;
  localparam int EXC_B_SYS    = 2;
  localparam int EXC_B_BP     = 3;
  localparam int EXC_B_OV     = 4;
  localparam int EXC_B_ADEL_D = 5;
  localparam int EXC_B_ADES   = 6;
  localparam int EXC_FLAGS    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Which source, if any, feeds BadVAddr for the winning exception.
  typedef enum logic [1:0] {
    BV_HOLD = 2'd0,
    BV_PC   = 2'd1,
    BV_ADDR = 2'd2
  } badv_sel_e;

endpackage

// File: rtl/exception_commit_if.sv
// Commit handshake from the memory/writeback stage and the flush/redirect
// path back to fetch.
interface exception_commit_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [6:0]  commit_exc;
  logic [31:0] commit_badaddr;
  logic        commit_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output commit_valid, commit_pc, commit_bd, commit_exc, commit_badaddr, commit_eret,
    input  commit_ready, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_bd, commit_exc, commit_badaddr, commit_eret,
    output commit_ready, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_commit_exc_priority_enc.sv
// Combinational priority pick among the pending interrupt and the commit
// exception flags; yields ExcCode, a taken flag and the BadVAddr source.
module exc_priority_enc
  import exception_commit_pkg::*;
(
  input  logic                 int_pend,
  input  logic [EXC_FLAGS-1:0] exc,
  output logic                 taken,
  output logic [4:0]           code,
  output badv_sel_e            badv_sel
);

  always_comb begin
    taken    = 1'b1;
    code     = EXC_INT;
    badv_sel = BV_HOLD;
    if (int_pend) begin
      code = EXC_INT;
    end else if (exc[EXC_B_ADEL_F]) begin
      code     = EXC_ADEL;
      badv_sel = BV_PC;
    end else if (exc[EXC_B_RI]) begin
      code = EXC_RI;
    end else if (exc[EXC_B_SYS]) begin
      code = EXC_SYS;
    end else if (exc[EXC_B_BP]) begin
      code = EXC_BP;
    end else if (exc[EXC_B_OV]) begin
      code = EXC_OV;
    end else if (exc[EXC_B_ADEL_D]) begin
      code     = EXC_ADEL;
      badv_sel = BV_ADDR;
    end else if (exc[EXC_B_ADES]) begin
      code     = EXC_ADES;
      badv_sel = BV_ADDR;
    end else begin
      taken = 1'b0;
    end
  end

endmodule

// File: rtl/exception_commit.sv
// Precise exception / interrupt commit unit: latches CP0 exception state and
// issues a one-cycle flush+redirect. Optional timer: define EXC_TIMER_INT_EN.
module exception_commit
  import exception_commit_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VEC    = 32'hbfc0_0380
) (
  input  logic                  clk,
  input  logic                  rst,
  exception_commit_if.slave     cif,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic [NUM_HW_INT-1:0] int_mask,
  input  logic                  status_ie,
`ifdef EXC_TIMER_INT_EN
  input  logic                  compare_we,
  input  logic [31:0]           compare_wdata,
  output logic                  timer_int,
`endif
  output logic [4:0]            exc_code,
  output logic                  cause_bd,
  output logic [NUM_HW_INT-1:0] cause_ip,
  output logic [31:0]           epc,
  output logic [31:0]           badvaddr,
  output logic                  status_exl
);

  state_e                state;
  logic                  flush_q, rv_q, ready_q;
  logic [31:0]           rpc_q;
  logic [NUM_HW_INT-1:0] sync1, sync2;
  logic                  int_pend, taken;
  logic [4:0]            code;
  badv_sel_e             badv_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= hw_int;
      sync2 <= sync1;
    end
  end

`ifdef EXC_TIMER_INT_EN
  logic [31:0] count, compare;
  logic        half;

  // compare resets to all-ones so the timer stays quiet until programmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      half      <= 1'b0;
      compare   <= '1;
      timer_int <= 1'b0;
    end else begin
      half  <= ~half;
      count <= count + {31'd0, half};
      if (compare_we) begin
        compare   <= compare_wdata;
        timer_int <= 1'b0;
      end else if (count == compare) begin
        timer_int <= 1'b1;
      end
    end
  end

  assign cause_ip = sync2 | {timer_int, {(NUM_HW_INT-1){1'b0}}};
`else
  assign cause_ip = sync2;
`endif

  assign int_pend = (|(cause_ip & int_mask)) & status_ie & ~status_exl;

  exc_priority_enc u_prio (
    .int_pend (int_pend),
    .exc      (cif.commit_exc),
    .taken    (taken),
    .code     (code),
    .badv_sel (badv_sel)
  );

  assign cif.commit_ready   = ready_q;
  assign cif.flush          = flush_q;
  assign cif.redirect_valid = rv_q;
  assign cif.redirect_pc    = rpc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_q    <= 1'b0;
      rv_q       <= 1'b0;
      ready_q    <= 1'b1;
      rpc_q      <= '0;
      exc_code   <= '0;
      cause_bd   <= 1'b0;
      epc        <= '0;
      badvaddr   <= '0;
      status_exl <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          flush_q <= 1'b0;
          rv_q    <= 1'b0;
          ready_q <= 1'b1;
          if (cif.commit_valid && taken) begin
            exc_code <= code;
            // Nested exception: keep the original return point.
            if (!status_exl) begin
              epc      <= cif.commit_bd ? cif.commit_pc - 32'd4 : cif.commit_pc;
              cause_bd <= cif.commit_bd;
            end
            case (badv_sel)
              BV_PC:   badvaddr <= cif.commit_pc;
              BV_ADDR: badvaddr <= cif.commit_badaddr;
              default: ;
            endcase
            status_exl <= 1'b1;
            rpc_q      <= EXC_VEC;
            flush_q    <= 1'b1;
            rv_q       <= 1'b1;
            ready_q    <= 1'b0;
            state      <= ST_FLUSH;
          end else if (cif.commit_valid && cif.commit_eret) begin
            status_exl <= 1'b0;
            rpc_q      <= epc;
            flush_q    <= 1'b1;
            rv_q       <= 1'b1;
            ready_q    <= 1'b0;
            state      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b0;
          rv_q    <= 1'b0;
          ready_q <= 1'b0;
          state   <= ST_HOLD;
        end
        ST_HOLD: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          flush_q <= 1'b0;
          rv_q    <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exception_commit.md
# exception_commit

Parametrised precise-exception and interrupt commit unit at the memory/writeback boundary of the MIPS pipeline. Prioritises the exception flags carried by the committing instruction together with synchronised hardware interrupts, and latches EPC, Cause.ExcCode, Cause.BD, BadVAddr and Status.EXL. Drives a registered pipeline flush and PC redirect for exceptions and ERET, then holds off further commits until the redirect has been issued.

## Interface
- NUM_HW_INT, 6: number of hardware interrupt lines (1..8).
- EXC_VEC, 32'hbfc0_0380: exception entry address.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- commit_valid  in  1  instruction present at commit.
- commit_ready  out  1  unit accepts a commit this cycle.
- commit_pc  in  32  PC of committing instruction.
- commit_bd  in  1  instruction is in a branch delay slot.
- commit_exc  in  7  flags: [0] AdEL-fetch, [1] RI, [2] Sys, [3] Bp, [4] Ov, [5] AdEL-data, [6] AdES.
- commit_badaddr  in  32  data address for [5]/[6].
- commit_eret  in  1  instruction is ERET.
- hw_int  in  NUM_HW_INT  asynchronous interrupt lines.
- int_mask  in  NUM_HW_INT  Status.IM from CP0.
- status_ie  in  1  Status.IE from CP0.
- flush  out  1  squash all younger stages.
- redirect_valid  out  1  redirect_pc is to be loaded into the PC.
- redirect_pc  out  32  new fetch address.
- exc_code  out  5  Cause.ExcCode.
- cause_bd  out  1  Cause.BD.
- cause_ip  out  NUM_HW_INT  synchronised pending interrupt lines.
- epc  out  32  EPC.
- badvaddr  out  32  BadVAddr.
- status_exl  out  1  Status.EXL.

## Operation
- A commit is accepted when commit_valid & commit_ready.
- hw_int passes through a 2-flop synchroniser. cause_ip is the second stage.
- int_pend = |(cause_ip & int_mask) & status_ie & ~status_exl.
- Priority for an accepted commit, highest first: Int (0x00), AdEL-fetch (0x04), RI (0x0a), Sys (0x08), Bp (0x09), Ov (0x0c), AdEL-data (0x04), AdES (0x05), then ERET.
- Exception taken (int_pend or any commit_exc bit):
  - exc_code is updated.
  - If status_exl = 0: epc ← commit_bd ? commit_pc − 4 : commit_pc, and cause_bd ← commit_bd. If status_exl = 1, epc and cause_bd are held.
  - status_exl ← 1.
  - Redirect target is EXC_VEC.
- BadVAddr: on AdEL-fetch, badvaddr ← commit_pc. On AdEL-data or AdES, badvaddr ← commit_badaddr. Held for all other codes.
- ERET taken only when no exception or interrupt is taken in the same cycle: status_exl ← 0, redirect target is the current epc.
- FSM states:
  - IDLE: commit_ready = 1.
  - An accepted exception or ERET moves IDLE → FLUSH.
  - FLUSH: flush = 1, redirect_valid = 1, redirect_pc = the latched target, commit_ready = 0. Moves to HOLD unconditionally.
  - HOLD: commit_ready = 0. Moves to IDLE unconditionally.
- Accepted commits with no event leave all state unchanged.
- EPC subtraction is mod 2^32, so 0x0000_0000 with BD set gives 0xffff_fffc.

## Timing
- Event accepted in cycle N: architectural registers updated at the edge ending N. flush/redirect_valid high for exactly cycle N+1. commit_ready returns high at N+3.
- Interrupt latency from a hw_int edge to cause_ip: 2 cycles. It is taken only on an accepted commit.
- commit_valid during FLUSH or HOLD is ignored and must be held by upstream.
- Reset values: FSM IDLE, flush 0, redirect_valid 0, redirect_pc 0, commit_ready 1, exc_code 0, cause_bd 0, cause_ip 0, epc 0, badvaddr 0, status_exl 0, synchroniser flops 0.
- rst asserted mid-FLUSH or mid-HOLD returns the unit to IDLE immediately. flush drops asynchronously.

## Configuration
- EXC_TIMER_INT_EN defined:
  - Adds an internal 32-bit count, incremented every second cycle and wrapping.
  - Adds inputs compare_we and compare_wdata[31:0], and output timer_int.
  - timer_int sets when count == compare, and clears on a compare write.
  - timer_int is ORed into cause_ip[NUM_HW_INT−1] after the synchroniser.
- EXC_TIMER_INT_EN undefined: those ports and the logic are absent. cause_ip is driven purely by hw_int.

## Structure
- Shared package/header: the exc_code constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), the commit_exc bit indices, and the FSM state encodings.
- One sub-module, exc_priority_enc: combinational priority selection to exc_code plus a taken flag.

## Test plan
- Reset released, hw_int = 0, commit with commit_exc = 7'b0000010 at pc 0x8000_0010 → cycle N+1 flush = 1, redirect_pc = 0xbfc0_0380. exc_code = 0x0a, epc = 0x8000_0010, status_exl = 1. commit_ready = 1 at N+3.
- Same-cycle Sys + AdES with commit_bd = 1 at pc 0x8000_0104 → exc_code = 0x08, epc = 0x8000_0100, cause_bd = 1, badvaddr unchanged.
- hw_int[2] rises, int_mask = 6'b000100, status_ie = 1, then a commit with no exception → exc_code = 0x00 two or more cycles later. With status_exl = 1 the interrupt is not taken.
- EXL = 1, then an AdEL-data commit with badaddr 0x0000_0003 → epc held, badvaddr = 0x0000_0003. A following ERET → redirect_pc = held epc, status_exl = 0.
- Assert rst during FLUSH → flush = 0 immediately, all outputs at reset values, commit_ready = 1.
- With EXC_TIMER_INT_EN: write compare = 10 → timer_int high at count 10, cleared by the next compare write.
